fifo_drain_ctrl: RTL and testbench

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

---
 rtl/fifo_drain_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl
// Pops one word at a time from an external FIFO and streams it out byte by
// byte (LSB first) over a valid/ready byte interface.
//
// Optional feature: define FRAME_HEADER_EN to prefix every word with a
// header byte 8'hA5.
//
// Ports
//   clk          : system clock, rising-edge active
//   rst_n        : asynchronous active-low reset
//   enable       : permission to start a new word (sampled in IDLE and at
//                  the last byte accept only)
//   fifo_empty   : FIFO empty flag
//   fifo_counter : FIFO occupancy, status only
//   fifo_data    : FIFO registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   : FIFO read strobe, one pulse per word
//   tx_data      : outgoing byte
//   tx_valid     : tx_data valid
//   tx_ready     : sink accepts the byte when tx_valid && tx_ready
//   busy         : high in every state except IDLE
//   word_count   : words completed since reset (wraps at 2^16)
module fifo_drain_ctrl #(
  parameter int FIFO_WIDTH = 5,
  parameter int BUF_LENGTH = 63,
  parameter int NBYTES     = (BUF_LENGTH + 1) / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH:0]   fifo_counter,
  input  logic [BUF_LENGTH:0]   fifo_data,
  output logic                  fifo_rd_en,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [15:0]           word_count
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [7:0] HDR_BYTE = 8'hA5;

`ifdef FRAME_HEADER_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LATCH = 3'd2,
    ST_HDR   = 3'd3,
    ST_SEND  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd4
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [BUF_LENGTH:0] word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic [15:0]         wc_q, wc_d;
  logic                accept_s;
  logic                unused_ok_s;

  // Occupancy is informational only; the empty flag drives all decisions.
  assign unused_ok_s = ^fifo_counter;

  // Byte lane select: lane 0 is bits [7:0].
  function automatic logic [7:0] get_byte(input logic [BUF_LENGTH:0] word,
                                          input logic [IDX_W-1:0]    idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      b = (IDX_W'(i) == idx) ? word[i*8 +: 8] : b;
    end
    return b;
  endfunction

  assign accept_s = tx_valid_q && tx_ready;

  // Next-state and next-output computation; outputs are derived from the
  // next state so that the registered outputs line up with the state register.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    wc_d       = wc_q;
    rd_en_d    = 1'b0;
    tx_valid_d = 1'b0;
    busy_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // FIFO read data is valid now, one cycle after the strobe.
        word_d = fifo_data;
        idx_d  = '0;
`ifdef FRAME_HEADER_EN
        state_d   = ST_HDR;
        tx_data_d = HDR_BYTE;
`else
        state_d   = ST_SEND;
        tx_data_d = fifo_data[7:0];
`endif
      end
`ifdef FRAME_HEADER_EN
      ST_HDR: begin
        if (accept_s) begin
          state_d   = ST_SEND;
          tx_data_d = get_byte(word_q, '0);
        end else begin
          state_d = ST_HDR;
        end
      end
`endif
      ST_SEND: begin
        if (accept_s) begin
          if (idx_q == LAST_IDX) begin
            wc_d = wc_q + 16'd1;
            // Enable is only re-evaluated here, so a word is never truncated.
            if (enable && !fifo_empty) begin
              state_d = ST_RD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d     = idx_q + 1'b1;
            tx_data_d = get_byte(word_q, idx_q + 1'b1);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_en_d = (state_d == ST_RD);
`ifdef FRAME_HEADER_EN
    tx_valid_d = (state_d == ST_SEND) || (state_d == ST_HDR);
`else
    tx_valid_d = (state_d == ST_SEND);
`endif
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      wc_q       <= 16'd0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      wc_q       <= wc_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: a queue-based FIFO model feeds the
// DUT; expected bytes are queued when words are pushed and a negedge monitor
// pops and compares on every accepted byte.
module tb_fifo_drain_ctrl;

  localparam int FW = 5;
  localparam int BL = 63;
  localparam int NB = 8;
`ifdef FRAME_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int FRAME = NB + HDR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty = 1'b1;
  logic [FW:0]   fifo_counter = '0;
  logic [BL:0]   fifo_data = '0;
  logic          fifo_rd_en;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic [15:0]   word_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BL:0] fq[$];
  logic [7:0]  exp_q[$];
  int consumed     = 0;
  int wc_exp       = 0;
  int rd_count     = 0;
  int cyc          = 0;
  int last_rd_cyc  = -1;
  bit chk_period   = 1'b0;
  bit prev_stall   = 1'b0;
  logic [7:0] prev_data = 8'h00;

  fifo_drain_ctrl #(.FIFO_WIDTH(FW), .BUF_LENGTH(BL), .NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_counter(fifo_counter), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Push a word into the FIFO model and queue its expected byte stream.
  task automatic push_word(input logic [BL:0] w);
    fq.push_back(w);
    if (HDR != 0) exp_q.push_back(8'hA5);
    for (int i = 0; i < NB; i++) exp_q.push_back(w[i*8 +: 8]);
    fifo_empty   = 1'b0;
    fifo_counter = (FW+1)'(fq.size());
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (n < max && (exp_q.size() != 0 || busy || fq.size() != 0)) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0 || busy || fq.size() != 0) fail_now("idle_timeout");
  endtask

  task automatic wait_consumed(input int k);
    int n = 0;
    while (n < 200 && consumed != k) begin
      @(posedge clk); #1; n++;
    end
    if (consumed != k) fail_now("consumed_timeout");
  endtask

  // FIFO model: registered read data, one pop per strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() > 0) fifo_data <= fq.pop_front();
      else fail_now("fifo_underflow");
    end
    fifo_empty   <= (fq.size() == 0);
    fifo_counter <= (FW+1)'(fq.size());
  end

  // Monitor / scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      check("word_count", {16'd0, word_count}, wc_exp % 65536);
      if (fifo_rd_en) begin
        rd_count++;
        if (last_rd_cyc == cyc - 1) fail_now("rd_en_wide");
        if (chk_period && last_rd_cyc >= 0) check("rd_period", cyc - last_rd_cyc, FRAME + 2);
        last_rd_cyc = cyc;
      end
      if (prev_stall && !tx_valid) fail_now("valid_dropped");
      if (tx_valid) begin
        if (prev_stall) check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
        if (tx_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_byte");
          end else begin
            check("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
          end
          consumed++;
          if (consumed == FRAME) begin
            consumed = 0;
            wc_exp++;
          end
        end
        prev_stall = !tx_ready;
        prev_data  = tx_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int rd0;
    int pushed;
    rst_n    = 1'b0;
    enable   = 1'b0;
    tx_ready = 1'b0;
    #2;
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_word_count", {16'd0, word_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic drain of one known word.
    enable   = 1'b1;
    tx_ready = 1'b1;
    rd0 = rd_count;
    push_word(64'h0807060504030201);
    wait_idle(100);
    check("basic_rd_pulses", rd_count - rd0, 1);
    check("basic_busy", {31'd0, busy}, 32'd0);
    check("basic_wc", {16'd0, word_count}, 32'd1);

    // Backpressure at byte index 3.
    push_word(64'h0807060504030201);
    wait_consumed(HDR + 3);
    tx_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", {31'd0, tx_valid}, 32'd1);
      check("bp_data", {24'd0, tx_data}, 32'h04);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle(100);
    check("bp_wc", {16'd0, word_count}, 32'd2);

    // Back-to-back: three queued words, ready held high.
    last_rd_cyc = -1;
    chk_period  = 1'b1;
    rd0 = rd_count;
    for (int i = 0; i < 3; i++) push_word({$urandom, $urandom});
    wait_idle(200);
    chk_period = 1'b0;
    check("b2b_rd_pulses", rd_count - rd0, 3);
    check("b2b_wc", {16'd0, word_count}, 32'd5);

    // Enable drop mid-word: the word completes, no further pop.
    push_word({$urandom, $urandom});
    push_word({$urandom, $urandom});
    wait_consumed(HDR + 2);
    enable = 1'b0;
    rd0 = rd_count;
    begin
      int n = 0;
      while (n < 100 && exp_q.size() != FRAME) begin @(posedge clk); #1; n++; end
      if (exp_q.size() != FRAME) fail_now("drop_word_timeout");
    end
    repeat (20) @(posedge clk);
    #1;
    check("drop_no_rd", rd_count - rd0, 0);
    check("drop_busy", {31'd0, busy}, 32'd0);
    check("drop_fifo_left", fq.size(), 1);
    check("drop_wc", {16'd0, word_count}, 32'd6);
    enable = 1'b1;
    wait_idle(100);
    check("drop_wc2", {16'd0, word_count}, 32'd7);

    // Asynchronous reset in the middle of a word.
    push_word({$urandom, $urandom});
    wait_consumed(HDR + 5);
    rst_n = 1'b0;
    #1;
    check("mrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mrst_wc", {16'd0, word_count}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    for (int i = consumed; i < FRAME; i++) void'(exp_q.pop_front());
    consumed   = 0;
    wc_exp     = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_valid", {31'd0, tx_valid}, 32'd0);
    push_word(64'h1122334455667788);
    wait_idle(100);
    check("post_rst_wc", {16'd0, word_count}, 32'd1);

    // Randomized traffic: random ready, enable and push timing.
    pushed = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, 3) != 0);
      enable   = ($urandom_range(0, 4) != 0);
      if (pushed < 24 && $urandom_range(0, 9) == 0) begin
        push_word({$urandom, $urandom});
        pushed++;
      end
    end
    while (pushed < 24) begin
      push_word({$urandom, $urandom});
      pushed++;
    end
    tx_ready = 1'b1;
    enable   = 1'b1;
    wait_idle(2000);
    check("rand_wc", {16'd0, word_count}, 32'd25);
    check("rand_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
